fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port o_imem_req, output, 1 bit: instruction memory request.
REQ-006 SHALL have port o_imem_addr, output, `WORD_SIZE bits: request address, word-aligned.
REQ-007 SHALL have port i_imem_gnt, input, 1 bit: request accepted this cycle.
REQ-008 SHALL have port i_imem_rvalid, input, 1 bit: response data valid.
REQ-009 SHALL have port i_imem_rdata, input, `WORD_SIZE bits: fetched instruction.
REQ-010 SHALL have port i_redirect, input, 1 bit: branch/jump taken, restart fetch.
REQ-011 SHALL have port i_redirect_pc, input, `WORD_SIZE bits: redirect target.
REQ-012 SHALL have port o_valid, output, 1 bit: o_instr/o_pc hold a valid instruction for decode.
REQ-013 SHALL have port i_ready, input, 1 bit: decode accepts this cycle (pop on o_valid && i_ready).
REQ-014 SHALL have port o_instr, output, `WORD_SIZE bits: instruction to decode/immediate generation.
REQ-015 SHALL have port o_pc, output, `WORD_SIZE bits: address of o_instr.

Function
REQ-016 SHALL keep at most one memory transaction outstanding (granted, rvalid not yet seen).
REQ-017 SHALL run the FSM IDLE -> (req && gnt) -> WAIT -> (rvalid) -> IDLE, with WAIT -> (i_redirect) -> DROP -> (rvalid) -> IDLE.
REQ-018 SHALL assert o_imem_req in IDLE only when buffer count plus outstanding is below 2, and never in WAIT or DROP.
REQ-019 SHALL hold o_imem_addr equal to the PC and stable while o_imem_req is high without gnt.
REQ-020 SHALL advance PC by 4 on req && gnt, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 SHALL push {rdata, request address} into the buffer on rvalid in WAIT, and SHALL make it visible on o_valid the next cycle.
REQ-022 SHALL discard rvalid data in DROP, and SHALL ignore rvalid in IDLE.
REQ-023 SHALL present the oldest entry on o_instr/o_pc, holding it stable while o_valid && !i_ready.
REQ-024 SHALL keep the count unchanged on a simultaneous push and pop, and SHALL never overflow (guaranteed by REQ-018).
REQ-025 SHALL, on i_redirect, load PC with {i_redirect_pc[31:2], 2'b00}, flush the buffer (o_valid=0 next cycle), and take priority over a same-cycle push, pop or grant.
REQ-026 SHALL move a grant coinciding with i_redirect to DROP, not WAIT.
REQ-027 SHALL stay in DROP on a redirect while in DROP and update PC; rvalid together with redirect in WAIT SHALL be discarded and the FSM SHALL go to IDLE.
REQ-028 SHALL drive o_instr = 32'h0000_0013 (NOP) and o_pc = 0 whenever o_valid=0.
REQ-029 SHALL achieve minimum latency, with a zero-wait memory, of request at cycle N, rvalid at N+1, and o_valid at N+2.

Reset
REQ-030 SHALL, while i_rst_n=0 at a clock edge, set PC=RESET_PC, FSM=IDLE, buffer empty, o_valid=0, o_imem_req=0, o_instr=NOP, o_pc=0.
REQ-031 SHALL assert o_imem_req with o_imem_addr=RESET_PC in the first cycle after reset release.
REQ-032 SHALL discard any in-flight response on reset applied mid-transaction: the FSM returns to IDLE and a late rvalid is ignored.

Structure
REQ-033 SHALL place the FSM state encoding and the NOP constant in the shared defines alongside WORD_SIZE and the opcode defines.
REQ-034 SHALL implement the 2-entry buffer as sub-module fetch_fifo (push/pop/flush, count output, registered data).

Verification
REQ-035 SHALL cover reset release, gnt=1, rvalid at +1 and i_ready=1: addr 0,4,8 issued and o_pc 0,4,8 delivered in order, first o_valid 2 cycles after req.
REQ-036 SHALL cover i_ready=0 for 6 cycles: exactly 2 entries buffered, o_imem_req low, o_instr stable, no loss or duplication after release.
REQ-037 SHALL cover redirect to 32'h0000_0103 in WAIT: the old rvalid is dropped, the next addr is 32'h0000_0100, and o_valid is low the cycle after.
REQ-038 SHALL cover redirect coinciding with gnt and with rvalid: both responses are discarded and fetch resumes at the target.
REQ-039 SHALL cover RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
REQ-040 SHALL cover i_rst_n low for 1 cycle during WAIT: the late rvalid is ignored and the next req is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word size, NOP encoding,
// base opcodes, fetch FSM encoding and the instruction buffer entry layout.
package fetch_stage_pkg;

  localparam int WORD_SIZE = 32;

  // ADDI x0, x0, 0 -- presented to decode whenever no instruction is valid
  localparam logic [WORD_SIZE-1:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [WORD_SIZE-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [WORD_SIZE-1:0] PC_STEP         = 32'd4;

  // RV32I base opcodes (bits [6:0] of an instruction)
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  // IDLE: free to request; WAIT: response pending and wanted;
  // DROP: response pending but stale after a redirect
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer. Entry 0 is always the oldest; a pop shifts
// entry 1 down. Flush empties the buffer by clearing the count only.
module fetch_fifo
  import fetch_stage_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic [1:0]   o_count
);

  logic [1:0]   r_count;
  fetch_entry_t r_slot0;
  fetch_entry_t r_slot1;
  logic         w_pop_ok;
  logic         w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only accepted when a pop frees a slot
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  assign o_data  = r_slot0;
  assign o_count = r_count;

  // Occupancy: flush wins over push/pop; push+pop leaves it unchanged
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + 2'd1;
    end else if (w_pop_ok && !w_push_ok) begin
      r_count <= r_count - 2'd1;
    end
  end

  // Entry storage: data only, validity is carried by the count
  always_ff @(posedge i_clk) begin
    if (w_pop_ok) begin
      if (r_count == 2'd2) begin
        r_slot0 <= r_slot1;
        if (i_push) begin
          r_slot1 <= i_data;
        end
      end else begin
        r_slot0 <= i_data;
      end
    end else if (w_push_ok) begin
      if (r_count == 2'd0) begin
        r_slot0 <= i_data;
      end else begin
        r_slot1 <= i_data;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word-aligned request at a time to the
// instruction memory, buffers up to two responses and hands them to decode.
// A redirect restarts fetch at the target and discards anything in flight.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_imem_req,
  output logic [WORD_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [WORD_SIZE-1:0] i_imem_rdata,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_instr,
  output logic [WORD_SIZE-1:0] o_pc
);

  fetch_state_e         r_state;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_req_addr;

  logic                 w_outstanding;
  logic                 w_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_count;
  logic [WORD_SIZE-1:0] w_redirect_pc;
  fetch_entry_t         w_push_entry;
  fetch_entry_t         w_head;

  assign w_outstanding = (r_state != FS_IDLE);
  assign w_redirect_pc = i_redirect_pc & WORD_ALIGN_MASK;

  // Request only when a returning word is guaranteed a buffer slot; derived
  // from registered state so the buffer count is seen without a cycle of lag.
  assign o_imem_req  = i_rst_n && (r_state == FS_IDLE) &&
                       ((32'(w_count) + 32'(w_outstanding)) < FIFO_DEPTH);
  assign o_imem_addr = r_pc;
  assign w_fire      = o_imem_req && i_imem_gnt;

  // A response is kept only in WAIT and only if no redirect lands with it
  assign w_push       = (r_state == FS_WAIT) && i_imem_rvalid && !i_redirect;
  assign w_pop        = o_valid && i_ready;
  assign w_push_entry = '{instr: i_imem_rdata, pc: r_req_addr};

  // Fetch FSM and program counter; redirect overrides the grant increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      if (i_redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_fire) begin
        r_pc <= r_pc + PC_STEP;
      end
      case (r_state)
        FS_IDLE: begin
          if (w_fire) begin
            r_state <= i_redirect ? FS_DROP : FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (i_imem_rvalid) begin
            r_state <= FS_IDLE;
          end else if (i_redirect) begin
            r_state <= FS_DROP;
          end
        end
        FS_DROP: begin
          if (i_imem_rvalid) begin
            r_state <= FS_IDLE;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  // Remember the address of the granted request to tag its response
  always_ff @(posedge i_clk) begin
    if (w_fire) begin
      r_req_addr <= r_pc;
    end
  end

  fetch_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign o_valid = (w_count != 2'd0);
  assign o_instr = o_valid ? w_head.instr : NOP_INSTR;
  assign o_pc    = o_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (RESET_PC 0 and FFFF_FFF8) share one
// input stream; a transaction-level model per instance predicts every output.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, rvalid, redirect, ready;
  logic [31:0] rdata, redirect_pc;
  logic        o_req   [2];
  logic        o_valid [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_instr [2];
  logic [31:0] o_pcv   [2];

  fetch_stage #(.RESET_PC(RPC0), .FIFO_DEPTH(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(o_req[0]), .o_imem_addr(o_addr[0]),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_valid(o_valid[0]),
    .i_ready(ready), .o_instr(o_instr[0]), .o_pc(o_pcv[0]));

  fetch_stage #(.RESET_PC(RPC1), .FIFO_DEPTH(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(o_req[1]), .o_imem_addr(o_addr[1]),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_valid(o_valid[1]),
    .i_ready(ready), .o_instr(o_instr[1]), .o_pc(o_pcv[1]));

  // Reference model: next PC, one pending transaction (maybe stale), buffer queue
  logic [31:0] m_pc    [2];
  logic [31:0] m_paddr [2];
  bit          m_pend  [2];
  bit          m_drop  [2];
  ent_t        m_q     [2][$];

  // Memory responder: answers each grant after a chosen latency
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  // Stimulus knobs (percentages)
  bit          k_rst_n;
  int          k_gnt, k_ready, k_redir, k_spur, k_rstp, k_lat_lo, k_lat_hi;
  bit          k_force;
  logic [31:0] k_force_pc;

  logic [31:0] fa0[$], fa1[$], dp0[$];
  int          cyc_n, first_fire, first_valid;
  int          n_chk, n_pass, n_fail;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF6;
      2:       return 32'h0000_0040;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model at the edge
  task automatic cyc();
    bit exp_req [2];
    bit fire0, take;
    rst_n       = k_rst_n && ($urandom_range(0, 99) >= k_rstp);
    rvalid      = mem_busy && (mem_cnt == 0);
    rdata       = rvalid ? memword(mem_addr) : $urandom();
    if (!mem_busy && ($urandom_range(0, 99) < k_spur)) rvalid = 1'b1;
    gnt         = !mem_busy && ($urandom_range(0, 99) < k_gnt);
    ready       = ($urandom_range(0, 99) < k_ready);
    redirect    = k_force || ($urandom_range(0, 99) < k_redir);
    redirect_pc = k_force ? k_force_pc : pick_target();
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_req[k] = rst_n && !m_pend[k] && (m_q[k].size() < 2);
      chk($sformatf("req%0d", k), 32'(o_req[k]), 32'(exp_req[k]));
      if (exp_req[k]) chk($sformatf("addr%0d", k), o_addr[k], m_pc[k]);
      chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(m_q[k].size() > 0));
      chk($sformatf("instr%0d", k), o_instr[k], (m_q[k].size() > 0) ? m_q[k][0].instr : NOP);
      chk($sformatf("pc%0d", k), o_pcv[k], (m_q[k].size() > 0) ? m_q[k][0].pc : 32'h0);
    end
    if (o_req[0] && gnt) begin
      fa0.push_back(o_addr[0]);
      if (first_fire < 0) first_fire = cyc_n;
    end
    if (o_req[1] && gnt) fa1.push_back(o_addr[1]);
    if (o_valid[0]) begin
      if (first_valid < 0) first_valid = cyc_n;
      if (ready) dp0.push_back(o_pcv[0]);
    end
    fire0 = exp_req[0] && gnt;
    @(posedge clk);
    if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt = mem_cnt - 1;
    if (fire0) begin
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(k_lat_lo, k_lat_hi)) - 1;
      mem_addr = m_pc[0];
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] = (k == 0) ? RPC0 : RPC1;
        m_q[k].delete();
        m_pend[k] = 1'b0;
        m_drop[k] = 1'b0;
      end else begin
        take = m_pend[k] && !m_drop[k] && rvalid && !redirect;
        if (redirect) m_q[k].delete();
        else begin
          if (m_q[k].size() > 0 && ready) void'(m_q[k].pop_front());
          if (take) m_q[k].push_back('{instr: rdata, pc: m_paddr[k]});
        end
        if (m_pend[k] && rvalid) m_pend[k] = 1'b0;
        else if (m_pend[k] && redirect) m_drop[k] = 1'b1;
        if (exp_req[k] && gnt) begin
          m_pend[k]  = 1'b1;
          m_drop[k]  = redirect;
          m_paddr[k] = m_pc[k];
        end
        if (redirect) m_pc[k] = redirect_pc & 32'hFFFF_FFFC;
        else if (exp_req[k] && gnt) m_pc[k] = m_pc[k] + 32'd4;
      end
    end
    cyc_n = cyc_n + 1;
    @(negedge clk);
    k_force = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; cyc_n = 0;
    first_fire = -1; first_valid = -1;
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    m_pc[0] = RPC0; m_pc[1] = RPC1;
    m_paddr[0] = '0; m_paddr[1] = '0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_drop[0] = 1'b0; m_drop[1] = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    k_rst_n = 1'b0; k_gnt = 100; k_ready = 100; k_redir = 0; k_spur = 0;
    k_rstp = 0; k_lat_lo = 1; k_lat_hi = 1; k_force = 1'b0; k_force_pc = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held: outputs idle
    repeat (2) cyc();

    // Release with zero-wait memory, decode always ready
    fa0.delete(); fa1.delete(); dp0.delete();
    k_rst_n = 1'b1; cyc_n = 0; first_fire = -1; first_valid = -1;
    repeat (8) cyc();
    chk("seq_addr0", qget(fa0, 0), 32'h0000_0000);
    chk("seq_addr1", qget(fa0, 1), 32'h0000_0004);
    chk("seq_addr2", qget(fa0, 2), 32'h0000_0008);
    chk("seq_pc0", qget(dp0, 0), 32'h0000_0000);
    chk("seq_pc1", qget(dp0, 1), 32'h0000_0004);
    chk("seq_pc2", qget(dp0, 2), 32'h0000_0008);
    chk("first_latency", 32'(first_valid - first_fire), 32'd2);
    chk("first_req_cycle", 32'(first_fire), 32'd0);
    chk("wrap_addr0", qget(fa1, 0), 32'hFFFF_FFF8);
    chk("wrap_addr1", qget(fa1, 1), 32'hFFFF_FFFC);
    chk("wrap_addr2", qget(fa1, 2), 32'h0000_0000);

    // Decode stalls for 6 cycles
    k_ready = 0;
    repeat (6) cyc();
    #1;
    chk("stall_req", 32'(o_req[0]), 32'd0);
    chk("stall_valid", 32'(o_valid[0]), 32'd1);
    chk("stall_pc", o_pcv[0], 32'h0000_000C);
    dp0.delete();
    k_ready = 100;
    repeat (8) cyc();
    chk("resume_pc0", qget(dp0, 0), 32'h0000_000C);
    chk("resume_pc1", qget(dp0, 1), 32'h0000_0010);
    chk("resume_pc2", qget(dp0, 2), 32'h0000_0014);
    chk("resume_pc3", qget(dp0, 3), 32'h0000_0018);

    // Redirect while waiting for a response
    k_lat_lo = 3; k_lat_hi = 3;
    for (int i = 0; i < 12 && !(m_pend[0] && !m_drop[0] && mem_cnt > 0); i++) cyc();
    chk("reach_wait", 32'(m_pend[0] && !m_drop[0] && mem_cnt > 0), 32'd1);
    k_force = 1'b1; k_force_pc = 32'h0000_0103;
    cyc();
    #1;
    chk("redir_flush", 32'(o_valid[0]), 32'd0);
    fa0.delete(); fa1.delete();
    for (int i = 0; i < 12 && fa0.size() == 0; i++) cyc();
    chk("redir_addr0", qget(fa0, 0), 32'h0000_0100);
    chk("redir_addr1", qget(fa1, 0), 32'h0000_0100);

    // Redirect coinciding with a grant
    k_lat_lo = 2; k_lat_hi = 2;
    for (int i = 0; i < 12 && !(!m_pend[0] && m_q[0].size() < 2 && !mem_busy); i++) cyc();
    chk("reach_grant", 32'(!m_pend[0] && m_q[0].size() < 2 && !mem_busy), 32'd1);
    k_force = 1'b1; k_force_pc = 32'h0000_0200;
    fa0.delete();
    cyc();
    fa0.delete();
    for (int i = 0; i < 12 && fa0.size() == 0; i++) cyc();
    chk("gnt_redir_addr", qget(fa0, 0), 32'h0000_0200);

    // Redirect coinciding with the response
    for (int i = 0; i < 12 && !(m_pend[0] && !m_drop[0] && mem_busy && mem_cnt == 0); i++) cyc();
    chk("reach_rvalid", 32'(m_pend[0] && !m_drop[0] && mem_busy && mem_cnt == 0), 32'd1);
    k_force = 1'b1; k_force_pc = 32'h0000_0300;
    cyc();
    #1;
    chk("rv_redir_valid", 32'(o_valid[0]), 32'd0);
    fa0.delete();
    for (int i = 0; i < 12 && fa0.size() == 0; i++) cyc();
    chk("rv_redir_addr", qget(fa0, 0), 32'h0000_0300);

    // One-cycle reset during WAIT; the late response must be ignored
    k_lat_lo = 3; k_lat_hi = 3;
    for (int i = 0; i < 12 && !(m_pend[0] && mem_cnt >= 1); i++) cyc();
    chk("reach_wait_rst", 32'(m_pend[0] && mem_cnt >= 1), 32'd1);
    k_rst_n = 1'b0;
    cyc();
    k_rst_n = 1'b1;
    fa0.delete(); fa1.delete();
    for (int i = 0; i < 12 && fa0.size() == 0; i++) cyc();
    chk("rst_addr0", qget(fa0, 0), RPC0);
    chk("rst_addr1", qget(fa1, 0), RPC1);

    // Randomized traffic
    k_gnt = 60; k_ready = 70; k_redir = 4; k_spur = 15; k_rstp = 1;
    k_lat_lo = 1; k_lat_hi = 3;
    repeat (600) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
